bcd_countdown_timer: RTL and testbench

- Two-digit-minute / two-digit-second BCD countdown timer (MM:SS) for the digital clock's timer mode.
- The up-counting timekeeping path adds with carry; this block does digit-wise BCD decrement with borrow.
- It is stepped by the shared 1 Hz enable pulse and drives the display mux and the alarm/beeper logic.

---
 rtl/bcd_countdown_timer.sv | 151 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer stepped by a shared 1 Hz enable, with expiry pulse and timed alert.
// Optional build macro TIMER_AUTO_RELOAD_EN: on expiry, reload the saved value and keep running.
module bcd_countdown_timer #(
    parameter int MIN_LIMIT   = 99,
    parameter int ALERT_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired_pulse,
    output logic       alert
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t     state, state_next;
    logic [7:0] min_next, sec_next;
    logic [7:0] save_min, save_sec, save_min_next, save_sec_next;
    logic       running_next, expired_next, alert_next;
    logic [3:0] alert_cnt, alert_cnt_next;

    logic [3:0] lm10, lm1, ls10, ls1;
    logic [6:0] lm_val, lm_clamped;
    logic [7:0] san_min, san_sec;
    logic [7:0] dec_min, dec_sec;
    logic       count_zero, dec_zero, tick_live;

    // Load sanitising: clamp each digit, then clamp the minutes value as a whole.
    always_comb begin
        lm10       = (load_min[7:4] > 4'd9) ? 4'd9 : load_min[7:4];
        lm1        = (load_min[3:0] > 4'd9) ? 4'd9 : load_min[3:0];
        ls10       = (load_sec[7:4] > 4'd5) ? 4'd5 : load_sec[7:4];
        ls1        = (load_sec[3:0] > 4'd9) ? 4'd9 : load_sec[3:0];
        lm_val     = 7'(lm10) * 7'd10 + 7'(lm1);
        lm_clamped = (lm_val > 7'(MIN_LIMIT)) ? 7'(MIN_LIMIT) : lm_val;
        san_min    = {4'(lm_clamped / 7'd10), 4'(lm_clamped % 7'd10)};
        san_sec    = {ls10, ls1};
    end

    always_comb begin
        dec_min = min_bcd;
        dec_sec = sec_bcd;
        if (sec_bcd[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_bcd[3:0] - 4'd1;
        end else begin
            dec_sec[3:0] = 4'd9;
            if (sec_bcd[7:4] != 4'd0) begin
                dec_sec[7:4] = sec_bcd[7:4] - 4'd1;
            end else begin
                dec_sec[7:4] = 4'd5;
                if (min_bcd[3:0] != 4'd0) begin
                    dec_min[3:0] = min_bcd[3:0] - 4'd1;
                end else begin
                    dec_min[3:0] = 4'd9;
                    dec_min[7:4] = min_bcd[7:4] - 4'd1;
                end
            end
        end
    end

    assign count_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
    assign dec_zero   = (dec_min == 8'h00) && (dec_sec == 8'h00);
    // A tick coinciding with load or pause is dropped entirely, for the count and the alert timer.
    assign tick_live  = tick_1hz && !load && !pause;

    always_comb begin
        state_next     = state;
        min_next       = min_bcd;
        sec_next       = sec_bcd;
        save_min_next  = save_min;
        save_sec_next  = save_sec;
        expired_next   = 1'b0;
        alert_next     = alert;
        alert_cnt_next = alert_cnt;

        if (alert && tick_live) begin
            if (alert_cnt == 4'(ALERT_TICKS - 1)) begin
                alert_next     = 1'b0;
                alert_cnt_next = 4'd0;
            end else begin
                alert_cnt_next = alert_cnt + 4'd1;
            end
        end

        if (load) begin
            min_next       = san_min;
            sec_next       = san_sec;
            save_min_next  = san_min;
            save_sec_next  = san_sec;
            state_next     = IDLE;
            alert_next     = 1'b0;
            alert_cnt_next = 4'd0;
        end else if (pause) begin
            if (state == RUN) state_next = PAUSE;
        end else if (start && (state == IDLE || state == PAUSE) && !count_zero) begin
            state_next = RUN;
        end else if (tick_1hz && state == RUN && !count_zero) begin
            if (dec_zero) begin
                expired_next   = 1'b1;
                alert_next     = 1'b1;
                alert_cnt_next = 4'd0;
`ifdef TIMER_AUTO_RELOAD_EN
                min_next       = save_min;
                sec_next       = save_sec;
`else
                min_next       = 8'h00;
                sec_next       = 8'h00;
                state_next     = EXPIRED;
`endif
            end else begin
                min_next = dec_min;
                sec_next = dec_sec;
            end
        end

        running_next = (state_next == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            min_bcd       <= 8'h00;
            sec_bcd       <= 8'h00;
            save_min      <= 8'h00;
            save_sec      <= 8'h00;
            running       <= 1'b0;
            expired_pulse <= 1'b0;
            alert         <= 1'b0;
            alert_cnt     <= 4'd0;
        end else begin
            state         <= state_next;
            min_bcd       <= min_next;
            sec_bcd       <= sec_next;
            save_min      <= save_min_next;
            save_sec      <= save_sec_next;
            running       <= running_next;
            expired_pulse <= expired_next;
            alert         <= alert_next;
            alert_cnt     <= alert_cnt_next;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a default instance plus one built with MIN_LIMIT=30.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [7:0] min_bcd, sec_bcd, min30, sec30;
    logic       running, expired_pulse, alert;
    logic       running30, expired30, alert30;

    // Expected word: {min[7:0], sec[7:0], running, expired_pulse, alert}
    logic [18:0] exp_q[$];
    logic [15:0] exp30_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
        .expired_pulse(expired_pulse), .alert(alert)
    );

    bcd_countdown_timer #(.MIN_LIMIT(30), .ALERT_TICKS(5)) dut30 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
        .min_bcd(min30), .sec_bcd(sec30), .running(running30),
        .expired_pulse(expired30), .alert(alert30)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic cyc(input string tag,
                       input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                       input logic st, input logic pa, input logic tk, input logic rs,
                       input logic [7:0] em, input logic [7:0] es,
                       input logic er, input logic ee, input logic ea);
        logic [18:0] e;
        logic [15:0] e30;
        exp_q.push_back({em, es, er, ee, ea});
        load = ld; load_min = lm; load_sec = ls;
        start = st; pause = pa; tick_1hz = tk; rst = rs;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick_1hz = 1'b0; rst = 1'b0;
        e = exp_q.pop_front();
        check({tag, ".min"}, 32'(min_bcd), 32'(e[18:11]));
        check({tag, ".sec"}, 32'(sec_bcd), 32'(e[10:3]));
        check({tag, ".running"}, 32'(running), 32'(e[2]));
        check({tag, ".expired"}, 32'(expired_pulse), 32'(e[1]));
        check({tag, ".alert"}, 32'(alert), 32'(e[0]));
        if (exp30_q.size() > 0) begin
            e30 = exp30_q.pop_front();
            check({tag, ".min30"}, 32'(min30), 32'(e30[15:8]));
            check({tag, ".sec30"}, 32'(sec30), 32'(e30[7:0]));
        end
    endtask

    task automatic idle(input string tag, input logic [7:0] em, input logic [7:0] es,
                        input logic er, input logic ee, input logic ea);
        cyc(tag, 0, 8'h00, 8'h00, 0, 0, 0, 0, em, es, er, ee, ea);
    endtask

    task automatic tick(input string tag, input logic [7:0] em, input logic [7:0] es,
                        input logic er, input logic ee, input logic ea);
        cyc(tag, 0, 8'h00, 8'h00, 0, 0, 1, 0, em, es, er, ee, ea);
    endtask

    task automatic do_load(input string tag, input logic [7:0] lm, input logic [7:0] ls,
                           input logic [7:0] em, input logic [7:0] es);
        cyc(tag, 1, lm, ls, 0, 0, 0, 0, em, es, 0, 0, 0);
    endtask

    task automatic do_start(input string tag, input logic [7:0] em, input logic [7:0] es,
                            input logic er);
        cyc(tag, 0, 8'h00, 8'h00, 1, 0, 0, 0, em, es, er, 0, 0);
    endtask

    initial begin
        // Reset, plus a stray tick right after it that must not move an idle zero count
        cyc("reset", 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        tick("post_reset_tick", 8'h00, 8'h00, 0, 0, 0);

        // 01:00 -> 00:59
        do_load("t1_load", 8'h01, 8'h00, 8'h01, 8'h00);
        do_start("t1_start", 8'h01, 8'h00, 1);
        tick("t1_tick", 8'h00, 8'h59, 1, 0, 0);

        // Full borrow ripple and load sanitising
        do_load("t2_load", 8'h10, 8'h00, 8'h10, 8'h00);
        do_start("t2_start", 8'h10, 8'h00, 1);
        tick("t2_tick", 8'h09, 8'h59, 1, 0, 0);
        exp30_q.push_back({8'h30, 8'h59});
        do_load("t2_bad_digits", 8'hAF, 8'h7C, 8'h99, 8'h59);
        exp30_q.push_back({8'h30, 8'h00});
        do_load("t2_clamp", 8'h45, 8'h00, 8'h45, 8'h00);

        // Expiry
        do_load("t3_load", 8'h00, 8'h02, 8'h00, 8'h02);
        do_start("t3_start", 8'h00, 8'h02, 1);
        tick("t3_tick1", 8'h00, 8'h01, 1, 0, 0);
`ifdef TIMER_AUTO_RELOAD_EN
        tick("t3_expire", 8'h00, 8'h02, 1, 1, 1);
        idle("t3_after", 8'h00, 8'h02, 1, 0, 1);
`else
        tick("t3_expire", 8'h00, 8'h00, 0, 1, 1);
        idle("t3_after", 8'h00, 8'h00, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            tick("t3_alert_hold", 8'h00, 8'h00, 0, 0, 1);
            idle("t3_alert_gap", 8'h00, 8'h00, 0, 0, 1);
        end
        tick("t3_alert_5th", 8'h00, 8'h00, 0, 0, 0);
        do_start("t3_start_ignored", 8'h00, 8'h00, 0);
`endif

        // Pause with coincident tick, ticks while paused, resume
        do_load("t4_load", 8'h00, 8'h30, 8'h00, 8'h30);
        do_start("t4_start", 8'h00, 8'h30, 1);
        tick("t4_tick1", 8'h00, 8'h29, 1, 0, 0);
        tick("t4_tick2", 8'h00, 8'h28, 1, 0, 0);
        tick("t4_tick3", 8'h00, 8'h27, 1, 0, 0);
        cyc("t4_pause_tick", 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'h00, 8'h27, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick("t4_paused_tick", 8'h00, 8'h27, 0, 0, 0);
        end
        do_start("t4_resume", 8'h00, 8'h27, 1);
        tick("t4_tick4", 8'h00, 8'h26, 1, 0, 0);

        // Zero load cannot start
        do_load("t5_load", 8'h00, 8'h00, 8'h00, 8'h00);
        do_start("t5_start", 8'h00, 8'h00, 0);
        tick("t5_tick", 8'h00, 8'h00, 0, 0, 0);

        // Reset wins over start and tick mid-run
        do_load("t6_load", 8'h05, 8'h17, 8'h05, 8'h17);
        do_start("t6_start", 8'h05, 8'h17, 1);
        cyc("t6_reset", 0, 8'h00, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0);
        do_start("t6_start_zero", 8'h00, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
